// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse-train generator.
// Optional init delay is enabled by PULSE_GEN_INIT_DELAY_EN.
package pulse_gen_pkg;

    localparam int CNT_W_DEF = 8;

    localparam logic MODE_BURST = 1'b0;
    localparam logic MODE_CONT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW
    } state_e;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle of the pulse-train generator.
// init_dly exists only with PULSE_GEN_INIT_DELAY_EN.
interface pulse_train_gen_if
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] count;
`ifdef PULSE_GEN_INIT_DELAY_EN
    logic [CNT_W-1:0] init_dly;
`endif
    logic             signal;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, mode,
        output high_len, low_len, count,
`ifdef PULSE_GEN_INIT_DELAY_EN
        output init_dly,
`endif
        input  signal, busy, done
    );

    modport slave (
        input  start, stop, mode,
        input  high_len, low_len, count,
`ifdef PULSE_GEN_INIT_DELAY_EN
        input  init_dly,
`endif
        output signal, busy, done
    );

endinterface

// File: rtl/pulse_train_gen_counter.sv
// Loadable saturating down-counter with a zero flag.
// Used as phase timer and as remaining-pulse counter.
module pulse_counter
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator (burst / continuous).
// Define PULSE_GEN_INIT_DELAY_EN for the initial-delay phase.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    pulse_train_gen_if.slave bus
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic             signal_q, signal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             t_load, t_en, t_zero;
    logic [CNT_W-1:0] t_val;
    logic             p_load, p_en, p_zero;
    logic [CNT_W-1:0] p_val;

    function automatic logic [CNT_W-1:0] m1(
        input logic [CNT_W-1:0] v
    );
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    pulse_counter #(.CNT_W(CNT_W)) u_phase (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (t_load),
        .value   (t_val),
        .en      (t_en),
        .zero    (t_zero)
    );

    pulse_counter #(.CNT_W(CNT_W)) u_pulses (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (p_load),
        .value   (p_val),
        .en      (p_en),
        .zero    (p_zero)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        high_d  = high_q;
        low_d   = low_q;
        done_d  = 1'b0;
        t_load  = 1'b0;
        t_en    = 1'b0;
        t_val   = '0;
        p_load  = 1'b0;
        p_en    = 1'b0;
        p_val   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    mode_d = bus.mode;
                    high_d = bus.high_len;
                    low_d  = bus.low_len;
                    if (bus.mode == MODE_BURST && bus.count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        p_load  = 1'b1;
                        p_val   = m1(bus.count);
                        t_load  = 1'b1;
                        state_d = HIGH;
                        t_val   = m1(bus.high_len);
`ifdef PULSE_GEN_INIT_DELAY_EN
                        if (bus.init_dly != '0) begin
                            state_d = DELAY;
                            t_val   = bus.init_dly - 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef PULSE_GEN_INIT_DELAY_EN
            DELAY: begin
                if (t_zero) begin
                    state_d = HIGH;
                    t_load  = 1'b1;
                    t_val   = m1(high_q);
                end else begin
                    t_en = 1'b1;
                end
            end
`endif
            HIGH: begin
                if (t_zero) begin
                    state_d = LOW;
                    t_load  = 1'b1;
                    t_val   = m1(low_q);
                end else begin
                    t_en = 1'b1;
                end
            end
            LOW: begin
                if (!t_zero) begin
                    t_en = 1'b1;
                end else if (mode_q == MODE_CONT || !p_zero) begin
                    state_d = HIGH;
                    t_load  = 1'b1;
                    t_val   = m1(high_q);
                    p_en    = (mode_q == MODE_BURST);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any transition computed above.
        if (bus.stop && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
            t_load  = 1'b0;
            t_en    = 1'b0;
            p_load  = 1'b0;
            p_en    = 1'b0;
        end

        signal_d = (state_d == HIGH);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= MODE_BURST;
            high_q   <= '0;
            low_q    <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            high_q   <= high_d;
            low_q    <= low_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.signal = signal_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train generator: on a start request it drives `signal` high for `high_len` clock cycles, then low for `low_len` cycles, and repeats. It runs for `count` pulses (burst mode) or until stopped (continuous mode). It is the parametrised successor of the fixed-period pulse block. It sits between the clock source and any block that needs timed strobes, replacing hard-coded `#` delays with cycle-counted, synthesizable timing.

## Interface
- `CNT_W`, 8: width of the length and count fields and of the internal counters.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a new train; sampled only in IDLE.
- `stop`  in  1  abort the running train; wins over every other event.
- `mode`  in  1  0 = burst (`count` pulses), 1 = continuous (ignores `count`).
- `high_len`  in  CNT_W  high-phase length in cycles; 0 is treated as 1.
- `low_len`  in  CNT_W  low-phase length in cycles; 0 is treated as 1.
- `count`  in  CNT_W  number of pulses in burst mode.
- `init_dly`  in  CNT_W  cycles before the first pulse (only with `PULSE_GEN_INIT_DELAY_EN`).
- `signal`  out  1  pulse output.
- `busy`  out  1  high while a train is active.
- `done`  out  1  one-cycle strobe when a burst completes normally.

## Operation
- States: IDLE, DELAY (macro only), HIGH, LOW.
- **IDLE**
  - With `start`=1: latch `mode`, `high_len`, `low_len`, `count` (and `init_dly`) into internal registers.
  - Go to HIGH, or to DELAY when the macro is set and `init_dly`≠0.
  - Input changes after the latch have no effect until the next start.
- **DELAY**: hold `signal`=0 for `init_dly` cycles, then go to HIGH.
- **HIGH**: `signal`=1 for max(high_len,1) cycles, then go to LOW.
- **LOW**
  - `signal`=0 for max(low_len,1) cycles.
  - On exit in burst mode, the remaining-pulse counter decrements. At 0, go to IDLE with `done`=1; otherwise go to HIGH.
  - In continuous mode, always go to HIGH.
- **Zero count**: burst with `count`=0 emits no pulse. The block goes IDLE→IDLE with `done`=1 in the following cycle and `busy` never rises.
- **Start while busy**: ignored; it is neither queued nor restarting.
- **stop**: in any non-IDLE state, the next cycle is IDLE with `signal`=0, `busy`=0 and `done`=0. Stop in IDLE is a no-op. Stop and start in the same IDLE cycle: stop wins, nothing starts.
- **Counters**: unsigned CNT_W down-counters loaded with length−1. No wrap-around; a counter reaching 0 triggers the transition.
- **Maximum train**: 2^CNT_W−1 pulses of 2^CNT_W−1 cycles per phase.

## Timing
- Reset values: `signal`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- Reset asserted mid-train forces these values immediately, without waiting for a clock edge.
- Start sampled at edge k:
  - `busy`=1 from cycle k+1.
  - `signal`=1 from cycle k+1, or from k+1+init_dly with the macro.
- Pulse period = max(high_len,1)+max(low_len,1) cycles.
- Burst end: `done` is high, and `busy` low, in the cycle after the final LOW cycle.
- A new start is accepted in that same `done` cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `PULSE_GEN_INIT_DELAY_EN` defined:
  - `init_dly` port and DELAY state exist.
  - `init_dly` is latched on start; a value of 0 skips DELAY.
- Not defined:
  - No `init_dly` port and no DELAY state.
  - The first pulse always starts in the cycle after start.

## Structure
- Package `pulse_gen_pkg`:
  - state enum (IDLE, DELAY, HIGH, LOW);
  - default `CNT_W`;
  - mode constants (`MODE_BURST`=0, `MODE_CONT`=1).
- Sub-module `pulse_counter`: loadable CNT_W down-counter with `load`, `value`, `en` and a `zero` flag.
  - One instance serves as the phase timer (HIGH/LOW/DELAY).
  - One instance serves as the pulse counter.

## Test plan
- **Reset**: assert `reset_n`=0 mid-HIGH → `signal`, `busy`, `done` = 0 at once; after release the block stays IDLE with no pulses.
- **Burst**: `high_len`=3, `low_len`=2, `count`=2, start at cycle 0 → `signal` high 1–3 and 6–8, low 4–5 and 9–10; `busy` high 1–10; `done` high only at 11.
- **Continuous then stop**: mode=1, `high_len`=48, `low_len`=48 → period 96 with no `done`; stop during HIGH → `signal`=0 and `busy`=0 next cycle, `done` stays 0.
- **Zero edge cases**:
  - `count`=0 → `done` one cycle after start, `signal` never high.
  - `high_len`=0, `low_len`=0 → period 2 (1 high, 1 low).
- **Restart and ignore**:
  - start during busy → ignored; the train completes unchanged.
  - start in the `done` cycle → new train, `signal` high in the next cycle.
- **Delay** (macro on): `init_dly`=5, start at cycle 0 → `busy` from 1, first `signal` high at cycle 6.
